// File: rtl/argo_fifo_write_arbiter.sv
// rtl/argo_fifo_write_arbiter.sv - round-robin arbiter sharing one argo_fifo write port
//
// Purpose: N producers compete for the single FIFO write port. The arbiter
// grants at most one write per cycle. It keeps its own count of free slots,
// so it never writes into a full FIFO, even though the FIFO's full flag lags.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   req          per-producer request, held with stable data until ack
//   req_data     producer i's word in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   ack          one-hot, one-cycle "word accepted" pulse
//   fifo_wr_en   FIFO write enable
//   fifo_wr_data FIFO write data
//   fifo_rd_en   copy of the FIFO read enable, returns credits
//   credits      free slots currently believed available
//   err          sticky underflow flag (read while believed empty)
module argo_fifo_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_rd_en,
  output logic [ADDR_WIDTH:0]           credits,
  output logic                          err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_CREDIT = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]    LAST_IDX   = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0]    ONE_PTR    = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0]    r_ack;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH:0]   r_credits;
  logic                  r_err;
  logic [PTR_W-1:0]      r_ptr;

  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_found;
  logic [PTR_W-1:0]      w_winner;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_grant;
  logic                  w_underflow;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [ADDR_WIDTH:0]   w_credits_nxt;

  // The requester acked this cycle still has req high; masking it stops a
  // second grant of the same word.
  assign w_eligible = req & ~r_ack;

  // Winner search starts at r_ptr and wraps modulo NUM_REQ.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_winner   = '0;
    w_onehot   = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!w_found && w_eligible[idx]) begin
        w_found       = 1'b1;
        w_winner      = PTR_W'(idx);
        w_onehot[idx] = 1'b1;
        w_sel_data    = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_grant     = w_found && (r_credits != '0);
  assign w_next_ptr  = (w_winner == LAST_IDX) ? '0 : w_winner + ONE_PTR;
  assign w_underflow = fifo_rd_en && (r_credits == DEPTH);

  // A read seen while the count is already at DEPTH is an underflow: it
  // returns no credit, so the count saturates instead of overshooting.
  always_comb begin
    w_credits_nxt = r_credits;
    if (w_grant) begin
      w_credits_nxt = w_credits_nxt - ONE_CREDIT;
    end
    if (fifo_rd_en && !w_underflow) begin
      w_credits_nxt = w_credits_nxt + ONE_CREDIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_credits <= DEPTH;
      r_err     <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_credits <= w_credits_nxt;
      if (w_underflow) begin
        r_err <= 1'b1;
      end
      if (w_grant) begin
        r_ack     <= w_onehot;
        r_wr_en   <= 1'b1;
        r_wr_data <= w_sel_data;
        r_ptr     <= w_next_ptr;
      end else begin
        r_ack     <= '0;
        r_wr_en   <= 1'b0;
        r_wr_data <= '0;
      end
    end
  end

  assign ack          = r_ack;
  assign fifo_wr_en   = r_wr_en;
  assign fifo_wr_data = r_wr_data;
  assign credits      = r_credits;
  assign err          = r_err;

endmodule

// File: tb/tb_argo_fifo_write_arbiter.sv
// tb/tb_argo_fifo_write_arbiter.sv - scoreboard bench for argo_fifo_write_arbiter
module tb_argo_fifo_write_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] req = '0;
  logic [DW-1:0] d [NR];
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] ack;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_rd_en = 1'b0;
  logic [AW:0]   credits;
  logic          err;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [NR-1:0] prev_ack = '0;

  always #5 clk = ~clk;

  assign req_data = {d[2], d[1], d[0]};

  argo_fifo_write_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en  (fifo_rd_en),
    .credits     (credits),
    .err         (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] data, input int idx);
    exp_t e;
    e.data = data;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Monitor: every write seen is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got data 0x%0h ack %b, expected no write at %0t",
                   fifo_wr_data, ack, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_data", 64'(fifo_wr_data), 64'(e.data));
          check("ack_onehot", 64'(ack), 64'(1) << e.idx);
        end
      end else begin
        check("idle_ack", 64'(ack), 64'(0));
        check("idle_wr_data", 64'(fifo_wr_data), 64'(0));
      end
      check("ack_single_pulse", 64'(ack & prev_ack), 64'(0));
      prev_ack = ack;
    end else begin
      prev_ack = '0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got;
    int cyc;

    // Reset held with all requests high.
    d[0] = 32'hA0; d[1] = 32'hB1; d[2] = 32'hC2;
    req  = 3'b111;
    rst  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ack", 64'(ack), 64'(0));
      check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
      check("rst_credits", 64'(credits), 64'(16));
      check("rst_err", 64'(err), 64'(0));
    end

    // Round-robin with all three requesters: writes every cycle.
    for (int r = 0; r < 2; r++) begin
      push(32'hA0, 0);
      push(32'hB1, 1);
      push(32'hC2, 2);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_wr_en", 64'(fifo_wr_en), 64'(1));
    end
    req = '0;
    tick();
    check("rr_credits", 64'(credits), 64'(10));

    // Single requester: one word every two cycles.
    d[1] = 32'h10;
    for (int i = 0; i < 4; i++) push(32'h10 + i, 1);
    req = 3'b010;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 20) begin
      tick();
      cyc++;
      if (ack[1]) begin
        got++;
        d[1] = d[1] + 1;
      end
    end
    req = '0;
    check("single_words", 64'(got), 64'(4));
    check("single_cycles", 64'(cyc), 64'(7));
    tick();
    check("single_credits", 64'(credits), 64'(6));

    // Credit exhaustion: only 6 credits left.
    d[0] = 32'h30;
    for (int i = 0; i < 6; i++) push(32'h30, 0);
    req = 3'b001;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack[0]) got++;
    end
    check("exhaust_words", 64'(got), 64'(6));
    check("exhaust_credits", 64'(credits), 64'(0));
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    check("rd_return_credit", 64'(credits), 64'(1));
    check("rd_no_same_edge_grant", 64'(ack), 64'(0));
    push(32'h30, 0);
    tick();
    check("after_rd_ack", 64'(ack), 64'(1));
    check("after_rd_credits", 64'(credits), 64'(0));
    for (int i = 0; i < 4; i++) tick();
    req = '0;
    tick();

    // Grant and read on the same edge.
    fifo_rd_en = 1'b1;
    tick();
    tick();
    fifo_rd_en = 1'b0;
    check("two_credits", 64'(credits), 64'(2));
    d[2] = 32'hC7;
    push(32'hC7, 2);
    req        = 3'b100;
    fifo_rd_en = 1'b1;
    tick();
    req        = '0;
    fifo_rd_en = 1'b0;
    check("simul_ack", 64'(ack), 64'(4));
    check("simul_credits", 64'(credits), 64'(2));
    tick();

    // Underflow after a fresh reset.
    rst = 1'b0;
    tick();
    tick();
    check("rst2_credits", 64'(credits), 64'(16));
    check("rst2_err", 64'(err), 64'(0));
    rst        = 1'b1;
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    check("uflow_err", 64'(err), 64'(1));
    check("uflow_credits", 64'(credits), 64'(16));
    d[0] = 32'h55; d[1] = 32'h66;
    push(32'h55, 0);
    push(32'h66, 1);
    req = 3'b011;
    tick();
    tick();
    req = '0;
    tick();
    check("uflow_err_sticky", 64'(err), 64'(1));
    check("uflow_after_credits", 64'(credits), 64'(14));

    // Reset asserted while a write is in flight.
    d[0] = 32'h77;
    req  = 3'b001;
    tick();
    check("inflight_wr_en", 64'(fifo_wr_en), 64'(1));
    rst = 1'b0;
    req = '0;
    #1;
    check("async_rst_wr_en", 64'(fifo_wr_en), 64'(0));
    check("async_rst_ack", 64'(ack), 64'(0));
    check("async_rst_err", 64'(err), 64'(0));
    check("async_rst_credits", 64'(credits), 64'(16));
    tick();
    rst = 1'b1;
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
